// File: rtl/pipe_trace_buffer.sv
// Retire-trace capture block: a circular log of MEM/WB write-backs with
// arm/trigger control, a post-trigger window and an oldest-first drain port.
module pipe_trace_buffer #(
    parameter int XLEN      = 64,
    parameter int PC_W      = 64,
    parameter int DEPTH     = 16,
    parameter int CNT_W     = 32,
    parameter int POST_TRIG = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wb_valid,
    input  logic [PC_W-1:0]          wb_pc,
    input  logic [4:0]               wb_rd,
    input  logic [XLEN-1:0]          wb_data,
    input  logic                     arm,
    input  logic                     abort,
    input  logic                     trig_force,
    input  logic                     trig_pc_en,
    input  logic [PC_W-1:0]          trig_pc,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [PC_W-1:0]          rd_pc,
    output logic [4:0]               rd_rd,
    output logic [XLEN-1:0]          rd_data,
    output logic [CNT_W-1:0]         rd_cycle,
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     wrapped
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] POST_LDV = AW'(POST_TRIG);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        TRIG  = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW:0]       count_q, count_d;
    logic [AW-1:0]     post_q, post_d;
    logic              wrapped_q, wrapped_d;
    logic [CNT_W-1:0]  cyc_q;
    logic              we;
    logic              trig_hit;
    logic [AW-1:0]     ridx;

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [4:0]        rd_mem   [DEPTH];
    logic [XLEN-1:0]   data_mem [DEPTH];
    logic [CNT_W-1:0]  cyc_mem  [DEPTH];

    assign trig_hit = trig_force || (trig_pc_en && wb_valid && (wb_pc == trig_pc));

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        count_d   = count_q;
        post_d    = post_q;
        wrapped_d = wrapped_q;
        we        = 1'b0;

        if (abort) begin
            state_d   = IDLE;
            count_d   = '0;
            wrapped_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (arm) begin
                        wptr_d    = '0;
                        count_d   = '0;
                        wrapped_d = 1'b0;
                        state_d   = ARMED;
                    end
                end
                ARMED: begin
                    we = wb_valid;
                    if (trig_hit) begin
                        post_d  = POST_LDV;
                        state_d = (POST_TRIG == 0) ? DONE : TRIG;
                    end
                end
                TRIG: begin
                    we = wb_valid;
                    if (wb_valid) begin
                        post_d = post_q - AW'(1);
                        if (post_q == AW'(1)) state_d = DONE;
                    end
                end
                DONE: begin
                    if (count_q == '0) begin
                        state_d = IDLE;
                    end else if (rd_ready) begin
                        count_d = count_q - (AW+1)'(1);
                        if (count_q == (AW+1)'(1)) state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase

            // A full log keeps its size; the write lands on the oldest slot.
            if (we) begin
                wptr_d = wptr_q + AW'(1);
                if (count_q == FULL) wrapped_d = 1'b1;
                else                 count_d   = count_q + (AW+1)'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            wptr_q    <= '0;
            count_q   <= '0;
            post_q    <= '0;
            wrapped_q <= 1'b0;
            cyc_q     <= '0;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            count_q   <= count_d;
            post_q    <= post_d;
            wrapped_q <= wrapped_d;
            cyc_q     <= cyc_q + CNT_W'(1);
        end
    end

    // NOTE: the log storage has no reset; stale slots are never shown because count gates every read.
    always_ff @(posedge clk) begin
        if (we) begin
            pc_mem[wptr_q]   <= wb_pc;
            rd_mem[wptr_q]   <= wb_rd;
            data_mem[wptr_q] <= wb_data;
            cyc_mem[wptr_q]  <= cyc_q;
        end
    end

    // Oldest entry; a full log wraps the subtraction back onto wptr itself.
    assign ridx     = wptr_q - count_q[AW-1:0];
    assign rd_valid = (state_q == DONE) && (count_q != '0);
    assign rd_pc    = rd_valid ? pc_mem[ridx]   : '0;
    assign rd_rd    = rd_valid ? rd_mem[ridx]   : '0;
    assign rd_data  = rd_valid ? data_mem[ridx] : '0;
    assign rd_cycle = rd_valid ? cyc_mem[ridx]  : '0;
    assign state    = state_q;
    assign count    = count_q;
    assign wrapped  = wrapped_q;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Bench for pipe_trace_buffer: two instances (post window 2 and 0) share stimulus;
// table rows drive the basic capture, a queue predicts the drained entries.
module tb_pipe_trace_buffer;

    localparam int XLEN  = 64;
    localparam int PC_W  = 64;
    localparam int DEPTH = 8;
    localparam int CNT_W = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              wb_valid = 1'b0;
    logic [PC_W-1:0]   wb_pc = '0;
    logic [4:0]        wb_rd = '0;
    logic [XLEN-1:0]   wb_data = '0;
    logic              arm = 1'b0, abort = 1'b0, trig_force = 1'b0, trig_pc_en = 1'b0;
    logic [PC_W-1:0]   trig_pc = '0;
    logic              rd_ready = 1'b0;

    logic              rd_valid, wrapped, rd_valid0, wrapped0;
    logic [PC_W-1:0]   rd_pc, rd_pc0;
    logic [4:0]        rd_rd, rd_rd0;
    logic [XLEN-1:0]   rd_data, rd_data0;
    logic [CNT_W-1:0]  rd_cycle, rd_cycle0;
    logic [1:0]        state, state0;
    logic [3:0]        count, count0;

    pipe_trace_buffer #(.XLEN(XLEN), .PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .POST_TRIG(2)) u_dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rd(wb_rd),
        .wb_data(wb_data), .arm(arm), .abort(abort), .trig_force(trig_force),
        .trig_pc_en(trig_pc_en), .trig_pc(trig_pc), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_rd(rd_rd), .rd_data(rd_data),
        .rd_cycle(rd_cycle), .state(state), .count(count), .wrapped(wrapped)
    );

    pipe_trace_buffer #(.XLEN(XLEN), .PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .POST_TRIG(0)) u_dut0 (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rd(wb_rd),
        .wb_data(wb_data), .arm(arm), .abort(abort), .trig_force(trig_force),
        .trig_pc_en(trig_pc_en), .trig_pc(trig_pc), .rd_ready(rd_ready),
        .rd_valid(rd_valid0), .rd_pc(rd_pc0), .rd_rd(rd_rd0), .rd_data(rd_data0),
        .rd_cycle(rd_cycle0), .state(state0), .count(count0), .wrapped(wrapped0)
    );

    always #5 clk = ~clk;

    // Reference cycle stamp: zero at a reset edge, +1 on every other edge.
    logic [CNT_W-1:0] tb_cyc = '0;
    always @(posedge clk) tb_cyc <= !reset ? '0 : tb_cyc + 1;

    typedef struct {
        logic [PC_W-1:0]  pc;
        logic [4:0]       rd;
        logic [XLEN-1:0]  data;
        logic [CNT_W-1:0] cyc;
    } entry_t;

    typedef struct {
        logic            arm;
        logic            wb_valid;
        logic [PC_W-1:0] wb_pc;
        logic [1:0]      exp_state;
        int              exp_count;
    } vec_t;

    entry_t sb[$];
    vec_t   vecs[8];
    int     n_tests = 0;
    int     n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one write-back; when it will be recorded, predict it (last DEPTH survive).
    task automatic drive_wb(input logic [PC_W-1:0] pc, input bit rec);
        entry_t e;
        wb_valid = 1'b1;
        wb_pc    = pc;
        wb_rd    = pc[6:2];
        wb_data  = {$urandom, $urandom};
        if (rec) begin
            e.pc = pc; e.rd = pc[6:2]; e.data = wb_data; e.cyc = tb_cyc;
            if (sb.size() == DEPTH) void'(sb.pop_front());
            sb.push_back(e);
        end
    endtask

    task automatic quiet();
        wb_valid = 1'b0; arm = 1'b0; abort = 1'b0; trig_force = 1'b0; rd_ready = 1'b0;
    endtask

    task automatic do_abort();
        quiet();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        sb.delete();
    endtask

    task automatic drain(input int n, input bit consec,
                         output logic [PC_W-1:0] first_pc, output logic [PC_W-1:0] last_pc);
        entry_t e;
        logic [CNT_W-1:0] prev = '0;
        first_pc = '0;
        last_pc  = '0;
        rd_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (sb.size() != 0) e = sb.pop_front();
            else                e = '{default: '0};
            check($sformatf("drain%0d_valid", i), rd_valid, 1'b1);
            check($sformatf("drain%0d_pc", i), rd_pc, e.pc);
            check($sformatf("drain%0d_rd", i), rd_rd, e.rd);
            check($sformatf("drain%0d_data", i), rd_data, e.data);
            check($sformatf("drain%0d_cycle", i), rd_cycle, e.cyc);
            if (consec && i > 0) check($sformatf("drain%0d_step", i), rd_cycle, prev + 1);
            prev = rd_cycle;
            if (i == 0) first_pc = rd_pc;
            last_pc = rd_pc;
            tick();
        end
        rd_ready = 1'b0;
    endtask

    task automatic run_table();
        logic [1:0] prev_state = 2'd0;
        trig_pc_en = 1'b1;
        trig_pc    = 64'h10;
        for (int i = 0; i < 8; i++) begin
            arm = vecs[i].arm;
            if (vecs[i].wb_valid) drive_wb(vecs[i].wb_pc, prev_state inside {2'd1, 2'd2});
            else                  wb_valid = 1'b0;
            tick();
            check($sformatf("vec%0d_state", i), state, vecs[i].exp_state);
            check($sformatf("vec%0d_count", i), count, vecs[i].exp_count);
            prev_state = vecs[i].exp_state;
        end
        quiet();
        trig_pc_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PC_W-1:0] fpc, lpc;

        //          arm   wbv   pc      state  count
        vecs[0] = '{1'b1, 1'b0, 64'h00, 2'd1, 0};
        vecs[1] = '{1'b0, 1'b1, 64'h00, 2'd1, 1};
        vecs[2] = '{1'b0, 1'b1, 64'h04, 2'd1, 2};
        vecs[3] = '{1'b0, 1'b1, 64'h08, 2'd1, 3};
        vecs[4] = '{1'b0, 1'b1, 64'h0C, 2'd1, 4};
        vecs[5] = '{1'b0, 1'b1, 64'h10, 2'd2, 5};
        vecs[6] = '{1'b0, 1'b1, 64'h14, 2'd2, 6};
        vecs[7] = '{1'b0, 1'b1, 64'h18, 2'd3, 7};

        // Reset with random inputs.
        for (int i = 0; i < 2; i++) begin
            wb_valid = 1'($urandom); arm = 1'($urandom); abort = 1'($urandom);
            trig_force = 1'($urandom); trig_pc_en = 1'($urandom); rd_ready = 1'($urandom);
            wb_pc = {$urandom, $urandom}; trig_pc = wb_pc;
            tick();
        end
        check("rst_state", state, 2'd0);
        check("rst_count", count, 0);
        check("rst_valid", rd_valid, 1'b0);
        check("rst_wrapped", wrapped, 1'b0);
        check("rst_rd_pc", rd_pc, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_rd", rd_rd, 0);
        check("rst_rd_cycle", rd_cycle, 0);
        check("rst_state0", state0, 2'd0);
        quiet();
        trig_pc_en = 1'b0;
        reset = 1'b1;
        tick();

        // Basic capture and ordered drain.
        do_abort();
        run_table();
        check("basic_wrapped", wrapped, 1'b0);
        drain(7, 1'b1, fpc, lpc);
        check("basic_first_pc", fpc, 64'h00);
        check("basic_last_pc", lpc, 64'h18);
        check("basic_idle", state, 2'd0);
        check("basic_valid_off", rd_valid, 1'b0);

        // Wrap, then backpressure and ignored inputs in DONE.
        do_abort();
        arm = 1'b1; tick(); arm = 1'b0;
        trig_pc_en = 1'b1; trig_pc = 64'h30;
        for (int i = 0; i < 15; i++) begin
            drive_wb(64'(i * 4), 1'b1);
            tick();
        end
        quiet();
        trig_pc_en = 1'b0;
        check("wrap_state", state, 2'd3);
        check("wrap_count", count, 8);
        check("wrap_wrapped", wrapped, 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (i == 1 || i == 3) drive_wb(64'h100, 1'b0);
            if (i == 2) arm = 1'b1;
            tick();
            quiet();
            check($sformatf("bp%0d_pc", i), rd_pc, sb[0].pc);
            check($sformatf("bp%0d_count", i), count, 8);
            check($sformatf("bp%0d_state", i), state, 2'd3);
        end
        drain(8, 1'b0, fpc, lpc);
        check("wrap_first_pc", fpc, 64'h1C);
        check("wrap_last_pc", lpc, 64'h38);
        check("wrap_idle", state, 2'd0);

        // Zero window: forced trigger with a write-back in the same cycle.
        do_abort();
        arm = 1'b1; tick(); arm = 1'b0;
        drive_wb(64'h40, 1'b0); tick();
        drive_wb(64'h44, 1'b0); trig_force = 1'b1; tick();
        quiet();
        check("force_state0", state0, 2'd3);
        check("force_count0", count0, 2);
        rd_ready = 1'b1;
        check("force_pc0_a", rd_pc0, 64'h40);
        tick();
        check("force_pc0_b", rd_pc0, 64'h44);
        tick();
        rd_ready = 1'b0;
        check("force_idle0", state0, 2'd0);

        // Zero window on an empty log: DONE for one cycle, never valid.
        do_abort();
        arm = 1'b1; tick(); arm = 1'b0;
        trig_force = 1'b1; tick(); trig_force = 1'b0;
        check("empty_done0", state0, 2'd3);
        check("empty_valid0_a", rd_valid0, 1'b0);
        tick();
        check("empty_idle0", state0, 2'd0);
        check("empty_valid0_b", rd_valid0, 1'b0);

        // Abort during TRIG with five entries.
        do_abort();
        arm = 1'b1; tick(); arm = 1'b0;
        trig_pc_en = 1'b1; trig_pc = 64'h10;
        for (int i = 0; i < 5; i++) begin
            drive_wb(64'(i * 4), 1'b1);
            tick();
        end
        quiet();
        trig_pc_en = 1'b0;
        check("abort_pre_state", state, 2'd2);
        check("abort_pre_count", count, 5);
        abort = 1'b1; arm = 1'b1; tick(); quiet();
        check("abort_state", state, 2'd0);
        check("abort_count", count, 0);
        check("abort_valid", rd_valid, 1'b0);

        // Reset mid-readout; the cycle stamp restarts from zero.
        do_abort();
        run_table();
        drain(3, 1'b1, fpc, lpc);
        check("mid_count", count, 4);
        reset = 1'b0; tick(); reset = 1'b1;
        sb.delete();
        check("mrst_state", state, 2'd0);
        check("mrst_count", count, 0);
        check("mrst_valid", rd_valid, 1'b0);
        check("mrst_rd_pc", rd_pc, 0);
        arm = 1'b1; tick(); arm = 1'b0;
        drive_wb(64'hA0, 1'b1); trig_force = 1'b1; tick(); trig_force = 1'b0;
        drive_wb(64'hA4, 1'b1); tick();
        drive_wb(64'hA8, 1'b1); tick();
        quiet();
        check("restart_state", state, 2'd3);
        check("restart_stamp", rd_cycle, 1);
        drain(3, 1'b1, fpc, lpc);
        check("restart_idle", state, 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_trace_buffer.md
Name: pipe_trace_buffer

Overview:
- Synthesizable retire-trace capture block for the pipelined RISC-V core; sits beside TopLevel and taps the MEM/WB write-back stream.
- Replaces the per-cycle bench dump with an on-chip circular log of retired write-backs, tagged as {cycle stamp, PC, rd, data}.
- Provides arm/trigger control with a configurable post-trigger window, then drains the log oldest-first over a valid/ready port.

Parameters:
- XLEN, 64, width of wb_data and rd_data.
- PC_W, 64, width of the PC fields.
- DEPTH, 16, number of entries; must be a power of 2 and at least 2.
- CNT_W, 32, width of the free-running cycle stamp.
- POST_TRIG, 8, entries recorded after the trigger entry; range 0..DEPTH-1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- wb_valid  in  1  a write-back retires this cycle
- wb_pc  in  PC_W  PC of the retiring instruction
- wb_rd  in  5  destination register (x0 is recorded too)
- wb_data  in  XLEN  write-back value
- arm  in  1  start capture; acted on only in IDLE
- abort  in  1  return to IDLE from any state and clear the log
- trig_force  in  1  immediate trigger, acted on only in ARMED
- trig_pc_en  in  1  enable the PC-match trigger
- trig_pc  in  PC_W  PC to match
- rd_ready  in  1  consumer accepts the current entry
- rd_valid  out  1  an entry is presented
- rd_pc  out  PC_W  presented entry PC
- rd_rd  out  5  presented entry rd
- rd_data  out  XLEN  presented entry data
- rd_cycle  out  CNT_W  presented entry cycle stamp
- state  out  2  current state: IDLE=0, ARMED=1, TRIG=2, DONE=3
- count  out  clog2(DEPTH)+1  entries held
- wrapped  out  1  at least one entry was overwritten during this capture

Behaviour:
- Reset (reset==0 at a clk edge) clears state to IDLE, count, write pointer, post counter, wrapped, and the cycle counter. All outputs are 0 the cycle after reset. Storage contents are don't-care. Reset has priority over every other input, including in mid-capture and mid-readout.
- The cycle counter increments every cycle out of reset and wraps modulo 2^CNT_W. An entry's stamp is the counter value in the cycle it is recorded.
- A record event is wb_valid in ARMED or TRIG. It writes array[wptr] and increments wptr modulo DEPTH. count saturates at DEPTH. If count==DEPTH at the write, the oldest entry is overwritten and wrapped is set.
- The oldest entry is at index (wptr - count) mod DEPTH.
- IDLE: if arm, clear wptr, count, and wrapped, then go to ARMED. wb_valid is ignored.
- ARMED: the trigger is trig_force, or (trig_pc_en && wb_valid && wb_pc==trig_pc).
  - A wb_valid in the trigger cycle is recorded as the trigger entry.
  - On trigger, load post counter = POST_TRIG and go to TRIG. If POST_TRIG==0, go directly to DONE.
- TRIG: each record event decrements the post counter. The record that brings it to 0 moves the state to DONE on the same edge. Trigger inputs are ignored.
- DONE: wb_valid is ignored and no writes occur.
  - rd_valid = (count != 0).
  - On rd_valid && rd_ready, count decrements and the next-oldest entry is presented the following cycle.
  - When count reaches 0, the state returns to IDLE on that edge.
  - If DONE is entered with count==0 (only possible via trig_force with no wb_valid and POST_TRIG==0 on an empty log), go to IDLE the next cycle.
- rd_* outputs are combinational from the oldest entry while rd_valid; all zero otherwise. While rd_ready is low, rd_* hold steady.
- abort in any state: next state IDLE, count=0, wrapped=0. abort takes priority over arm and over triggers in the same cycle.
- arm outside IDLE is ignored.
- Record latency: an entry is readable from the edge after wb_valid.

Test Plan:
- Reset: hold reset=0 for 2 cycles with random inputs -> state=0, count=0, rd_valid=0, wrapped=0, rd_* = 0.
- Basic capture (DEPTH=8, POST_TRIG=2): arm; wb pc 0x00,0x04,0x08,0x0C; trig_pc=0x10, wb 0x10; wb 0x14,0x18 -> DONE, count=7, wrapped=0; drain with rd_ready=1 yields pc 0x00..0x18 in order, stamps strictly increasing by 1; then IDLE.
- Wrap: arm; wb pc 0x00..0x2C (12 events) with no match; trigger at 0x30; post 0x34,0x38 -> count=8, wrapped=1, first rd_pc=0x1C, last rd_pc=0x38.
- Backpressure and ignore: in DONE hold rd_ready=0 for 5 cycles -> rd_pc constant; wb_valid pulses in DONE leave count unchanged; arm in DONE ignored.
- Force and zero-window (POST_TRIG=0): arm; wb 0x40; trig_force with wb 0x44 -> DONE next edge, count=2. trig_force on an empty log with wb_valid=0 -> DONE then IDLE, rd_valid never high.
- Abort and reset mid-operation: abort during TRIG with count=5 -> IDLE, count=0, rd_valid=0. reset=0 after 3 of 7 entries drained -> IDLE, count=0, cycle counter restarts at 0.
